// File: rtl/acia_bus_sequencer.sv
// acia_bus_sequencer
// Bus master for one MC6850-style ACIA. After reset it issues a master reset
// (CR=03) followed by the active control word. It then polls status and moves
// received bytes into an RX FIFO. Bytes from a TX FIFO go into the data
// register whenever the transmitter reports empty.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   tx_data/valid/ready     byte stream into the TX FIFO
//   rx_data/valid/ready     byte stream out of the RX FIFO
//   cfg_wr, cfg_cr          request a reconfiguration with a new control word
//   cfg_busy                a configuration sequence is owed or running
//   overrun, frame_err      sticky copies of status bits 5 and 4
//   acia_e/sel/rs/rw/wdata  ACIA register bus (rw=1 read, rs=1 data register)
//   acia_rdata, acia_irq    ACIA read data and interrupt
//
// Handshake: a byte moves on a stream only in a cycle where valid and ready
// are both 1. valid must not depend on ready. The sender holds the data
// stable while valid is high and ready is low.
//
// Every bus access lasts 4 cycles, P0..P3, and is tracked by acc/phase.
// The address, rw and write data are latched in bus_* when an access starts,
// so they cannot move while E is high.
module acia_bus_sequencer #(
  parameter logic [7:0] CFG_CR        = 8'h96,
  parameter int         POLL_INTERVAL = 64,
  parameter int         TX_AW         = 3,
  parameter int         RX_AW         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_cr,
  output logic       cfg_busy,
  output logic       overrun,
  output logic       frame_err,
  output logic       acia_e,
  output logic       acia_sel,
  output logic       acia_rs,
  output logic       acia_rw,
  output logic [7:0] acia_wdata,
  input  logic [7:0] acia_rdata,
  input  logic       acia_irq
);

  localparam logic [2:0] ST_RST  = 3'd0;
  localparam logic [2:0] ST_CFG  = 3'd1;
  localparam logic [2:0] ST_IDLE = 3'd2;
  localparam logic [2:0] ST_STAT = 3'd3;
  localparam logic [2:0] ST_RDAT = 3'd4;
  localparam logic [2:0] ST_WDAT = 3'd5;

  localparam logic [7:0] RST_CR = 8'h03;

  localparam int              PW       = $clog2(POLL_INTERVAL);
  localparam logic [PW-1:0]   POLL_MAX = PW'(POLL_INTERVAL - 1);
  localparam logic [PW-1:0]   POLL_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [TX_AW:0]  TX_DEPTH = {1'b1, {TX_AW{1'b0}}};
  localparam logic [TX_AW:0]  TX_ONE   = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0]  RX_DEPTH = {1'b1, {RX_AW{1'b0}}};
  localparam logic [RX_AW:0]  RX_ONE   = {{RX_AW{1'b0}}, 1'b1};

  logic [2:0]    state;
  logic          acc;
  logic [1:0]    phase;
  logic          bus_rs, bus_wr;
  logic [7:0]    bus_wd;
  logic [7:0]    rd_q;
  logic [7:0]    act_cr;
  logic          pending;
  logic          stat_tdre;
  logic [PW-1:0] poll_cnt;

  // ---------------- TX FIFO ----------------
  logic [7:0]   tx_mem [0:(1<<TX_AW)-1];
  logic [TX_AW:0] tx_wp, tx_rp, tx_cnt;
  logic         tx_empty, tx_push, tx_pop;
  logic [7:0]   tx_head;

  assign tx_cnt   = tx_wp - tx_rp;
  assign tx_empty = (tx_cnt == '0);
  assign tx_ready = (tx_cnt != TX_DEPTH);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = acc & (phase == 2'd3) & (state == ST_WDAT) & ~tx_empty;
  assign tx_head  = tx_mem[tx_rp[TX_AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_ONE;
      if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]   rx_mem [0:(1<<RX_AW)-1];
  logic [RX_AW:0] rx_wp, rx_rp, rx_cnt;
  logic         rx_full, rx_push, rx_pop;

  assign rx_cnt   = rx_wp - rx_rp;
  assign rx_full  = (rx_cnt == RX_DEPTH);
  assign rx_valid = (rx_cnt != '0);
  assign rx_data  = rx_mem[rx_rp[RX_AW-1:0]];
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_push  = acc & (phase == 2'd3) & (state == ST_RDAT) & ~rx_full;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= rd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_ONE;
      if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
    end
  end

  // ---------------- bus pins ----------------
  // Address and data phase covers P0..P2. P3 is the turnaround with sel low.
  logic in_addr;
  assign in_addr    = acc & (phase != 2'd3);
  assign acia_sel   = in_addr;
  assign acia_e     = acc & ((phase == 2'd1) | (phase == 2'd2));
  assign acia_rs    = in_addr & bus_rs;
  assign acia_rw    = ~(in_addr & bus_wr);
  assign acia_wdata = in_addr ? bus_wd : 8'h00;

  // ---------------- sequencer ----------------
  logic stat_trig, enter_stat;
  assign stat_trig  = acia_irq | (poll_cnt == POLL_MAX) | (~tx_empty & stat_tdre);
  assign enter_stat = ~acc & (state == ST_IDLE) & ~pending & stat_trig;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RST;
      acc       <= 1'b0;
      phase     <= 2'd0;
      bus_rs    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_wd    <= 8'h00;
      rd_q      <= 8'h00;
      act_cr    <= CFG_CR;
      pending   <= 1'b0;
      cfg_busy  <= 1'b1;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      stat_tdre <= 1'b0;
      poll_cnt  <= '0;
    end else begin
      // Saturates so a poll is still owed if it comes due mid-access.
      if (enter_stat)                poll_cnt <= '0;
      else if (poll_cnt != POLL_MAX) poll_cnt <= poll_cnt + POLL_ONE;

      if (acc) begin
        phase <= phase + 2'd1;
        if (phase == 2'd2) rd_q <= acia_rdata;
        if (phase == 2'd3) begin
          // Default: end of access, back to IDLE. Chained accesses override.
          acc   <= 1'b0;
          state <= ST_IDLE;
          case (state)
            ST_RST: begin
              state     <= ST_CFG;
              acc       <= 1'b1;
              bus_rs    <= 1'b0;
              bus_wr    <= 1'b1;
              bus_wd    <= act_cr;
              pending   <= 1'b0;
              overrun   <= 1'b0;
              frame_err <= 1'b0;
            end
            ST_CFG: begin
              if (!pending) cfg_busy <= 1'b0;
            end
            ST_STAT: begin
              overrun   <= overrun | rd_q[5];
              frame_err <= frame_err | rd_q[4];
              stat_tdre <= rd_q[1];
              if (pending) begin
                state  <= ST_RST;
                acc    <= 1'b1;
                bus_rs <= 1'b0;
                bus_wr <= 1'b1;
                bus_wd <= RST_CR;
              end else if (rd_q[0] && !rx_full) begin
                state  <= ST_RDAT;
                acc    <= 1'b1;
                bus_rs <= 1'b1;
                bus_wr <= 1'b0;
                bus_wd <= 8'h00;
              end else if (rd_q[1] && !tx_empty) begin
                state  <= ST_WDAT;
                acc    <= 1'b1;
                bus_rs <= 1'b1;
                bus_wr <= 1'b1;
                bus_wd <= tx_head;
              end
            end
            default: begin
              if (pending) begin
                state  <= ST_RST;
                acc    <= 1'b1;
                bus_rs <= 1'b0;
                bus_wr <= 1'b1;
                bus_wd <= RST_CR;
              end
            end
          endcase
        end
      end else if (state == ST_IDLE) begin
        if (pending) begin
          state  <= ST_RST;
          acc    <= 1'b1;
          bus_rs <= 1'b0;
          bus_wr <= 1'b1;
          bus_wd <= RST_CR;
        end else if (stat_trig) begin
          state  <= ST_STAT;
          acc    <= 1'b1;
          bus_rs <= 1'b0;
          bus_wr <= 1'b0;
          bus_wd <= 8'h00;
        end
      end else begin
        // Only reachable as RST straight out of reset.
        acc    <= 1'b1;
        bus_rs <= 1'b0;
        bus_wr <= 1'b1;
        bus_wd <= RST_CR;
      end

      // Placed last so a request on the same cycle as a sequence step wins.
      if (cfg_wr) begin
        act_cr   <= cfg_cr;
        pending  <= 1'b1;
        cfg_busy <= 1'b1;
      end
    end
  end

endmodule
